// File: rtl/load_store_unit.sv
// Data-memory side of the load/store path: drives a request/ack port with byte lanes and
// returns extended load data for write-back. Define MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [5:0]  control_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic        stall_o,
    output logic [31:0] wb_data_o,
    output logic        wb_valid_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [5:0] OpLb  = 6'b010000;
    localparam logic [5:0] OpLh  = 6'b010001;
    localparam logic [5:0] OpLw  = 6'b010010;
    localparam logic [5:0] OpLbu = 6'b010100;
    localparam logic [5:0] OpLhu = 6'b010101;
    localparam logic [5:0] OpSb  = 6'b011000;
    localparam logic [5:0] OpSh  = 6'b011001;
    localparam logic [5:0] OpSw  = 6'b011010;

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;
    typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

    state_e state_q, state_d;

    logic        is_mem, is_load, is_unsigned, trap;
    size_e       size;
    logic [1:0]  lo;
    logic [3:0]  be;
    logic [31:0] wdata;

    logic             load_q, load_d;
    logic             unsigned_q, unsigned_d;
    size_e            size_q, size_d;
    logic [1:0]       lo_q, lo_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             wb_valid_q, wb_valid_d;
    logic             err_q, err_d;

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;

    always_comb begin
        is_mem      = 1'b1;
        is_load     = 1'b1;
        is_unsigned = 1'b0;
        size        = SzByte;
        case (control_i)
            OpLb:  size = SzByte;
            OpLh:  size = SzHalf;
            OpLw:  size = SzWord;
            OpLbu: is_unsigned = 1'b1;
            OpLhu: begin
                size        = SzHalf;
                is_unsigned = 1'b1;
            end
            OpSb:  is_load = 1'b0;
            OpSh:  begin
                is_load = 1'b0;
                size    = SzHalf;
            end
            OpSw:  begin
                is_load = 1'b0;
                size    = SzWord;
            end
            default: begin
                is_mem  = 1'b0;
                is_load = 1'b0;
            end
        endcase
    end

    // Force-aligned lane offset; with the trap enabled misaligned ops never reach the port.
    always_comb begin
        case (size)
            SzWord:  lo = 2'b00;
            SzHalf:  lo = {addr_i[1], 1'b0};
            default: lo = addr_i[1:0];
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign trap = ((size == SzHalf) && addr_i[0]) || ((size == SzWord) && (addr_i[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        be    = 4'b1111;
        wdata = '0;
        if (!is_load) begin
            case (size)
                SzByte: begin
                    be    = 4'b0001 << lo;
                    wdata = {4{store_data_i[7:0]}};
                end
                SzHalf: begin
                    be    = lo[1] ? 4'b1100 : 4'b0011;
                    wdata = {2{store_data_i[15:0]}};
                end
                default: wdata = store_data_i;
            endcase
        end
    end

    assign rd_byte = mem_rdata_i[{lo_q, 3'b000} +: 8];
    assign rd_half = lo_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

    always_comb begin
        case (size_q)
            SzByte:  load_ext = {{24{~unsigned_q & rd_byte[7]}}, rd_byte};
            SzHalf:  load_ext = {{16{~unsigned_q & rd_half[15]}}, rd_half};
            default: load_ext = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            load_q     <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= SzByte;
            lo_q       <= 2'b00;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            wb_data_q  <= '0;
            wb_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_q     <= load_d;
            unsigned_q <= unsigned_d;
            size_q     <= size_d;
            lo_q       <= lo_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            wb_data_q  <= wb_data_d;
            wb_valid_q <= wb_valid_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_d     = load_q;
        unsigned_d = unsigned_q;
        size_d     = size_q;
        lo_d       = lo_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        wb_data_d  = wb_data_q;
        wb_valid_d = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            StIdle: begin
                if (valid_i && is_mem) begin
                    load_d     = is_load;
                    unsigned_d = is_unsigned;
                    size_d     = size;
                    lo_d       = lo;
                    we_d       = ~is_load;
                    addr_d     = {addr_i[31:2], 2'b00};
                    be_d       = be;
                    wdata_d    = wdata;
                    cnt_d      = '0;
                    if (trap) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (mem_ack_i) begin
                    state_d = StDone;
                    if (load_q) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = load_ext;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stall_o     = ~rst & (((state_q == StIdle) & valid_i & is_mem) | (state_q == StReq));
        mem_req_o   = (state_q == StReq);
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_be_o    = be_q;
        mem_wdata_o = wdata_q;
        wb_data_o   = wb_data_q;
        wb_valid_o  = wb_valid_q;
        err_o       = err_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a reference model queues expected memory requests
// and write-back results; a monitor compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_load_store_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [5:0]  control = '0;
    logic [31:0] addr_in = '0;
    logic [31:0] sd_in = '0;
    logic        stall_o, wb_valid_o, err_o, mem_req_o, mem_we_o;
    logic [31:0] wb_data_o, mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    load_store_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid),
        .control_i    (control),
        .addr_i       (addr_in),
        .store_data_i (sd_in),
        .stall_o      (stall_o),
        .wb_data_o    (wb_data_o),
        .wb_valid_o   (wb_valid_o),
        .err_o        (err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ack_i    (mem_ack),
        .mem_rdata_i  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;
    typedef struct {
        logic        is_err;
        logic [31:0] data;
    } res_t;

    req_t req_q[$];
    res_t res_q[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int stall_cnt = 0;
    int last_res_cyc = -1;
    bit req_seen = 1'b0;
    logic [5:0] ops [8] = '{6'b010000, 6'b010001, 6'b010010, 6'b010100, 6'b010101,
                            6'b011000, 6'b011001, 6'b011010};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: behaviour of one instruction from the op-code rules.
    function automatic void model(input logic [5:0] ctrl, input logic [31:0] addr,
                                  input logic [31:0] sd, input logic [31:0] rdata,
                                  output bit is_mem, output bit issued, output bit has_res,
                                  output req_t rq, output res_t rs);
        int nbytes, off;
        bit load, sgn;
        logic [31:0] mask, v;
        is_mem = 1; load = 0; sgn = 0; nbytes = 4;
        issued = 0; has_res = 0;
        rq = '{1'b0, 32'h0, 4'h0, 32'h0};
        rs = '{1'b0, 32'h0};
        case (ctrl)
            6'b010000: begin load = 1; sgn = 1; nbytes = 1; end
            6'b010001: begin load = 1; sgn = 1; nbytes = 2; end
            6'b010010: begin load = 1; nbytes = 4; end
            6'b010100: begin load = 1; nbytes = 1; end
            6'b010101: begin load = 1; nbytes = 2; end
            6'b011000: nbytes = 1;
            6'b011001: nbytes = 2;
            6'b011010: nbytes = 4;
            default:   is_mem = 0;
        endcase
        if (!is_mem) return;
`ifdef MISALIGN_TRAP_EN
        if ((int'(addr[1:0]) % nbytes) != 0) begin
            has_res = 1;
            rs = '{1'b1, 32'h0};
            return;
        end
`endif
        issued = 1;
        off = int'(addr[1:0]) / nbytes * nbytes;
        rq.we = !load;
        rq.addr = {addr[31:2], 2'b00};
        rq.be = load ? 4'hf : 4'(((1 << nbytes) - 1) << off);
        rq.wdata = (nbytes == 1) ? sd[7:0] * 32'h01010101 :
                   (nbytes == 2) ? sd[15:0] * 32'h00010001 : sd;
        if (load) begin
            has_res = 1;
            mask = (nbytes == 4) ? 32'hffffffff : (32'h1 << (8 * nbytes)) - 1;
            v = (rdata >> (8 * off)) & mask;
            if (sgn && v[8 * nbytes - 1]) v = v | ~mask;
            rs = '{1'b0, v};
        end
    endfunction

    // d = REQ cycles before ack; d >= TIMEOUT means the ack arrives too late.
    task automatic do_op(input logic [5:0] ctrl, input logic [31:0] addr, input logic [31:0] sd,
                         input int d, input logic [31:0] rdata, input string name);
        bit is_mem, issued, has_res, timed_out, got;
        req_t rq;
        res_t rs;
        int acc, exp_stall, exp_lat;
        model(ctrl, addr, sd, rdata, is_mem, issued, has_res, rq, rs);
        timed_out = issued && (d >= TIMEOUT);
        if (timed_out) begin
            has_res = 1;
            rs = '{1'b1, 32'h0};
        end
        if (issued) req_q.push_back(rq);
        if (has_res) res_q.push_back(rs);
        exp_stall = !is_mem ? 0 : !issued ? 1 : timed_out ? 1 + TIMEOUT : 2 + d;
        exp_lat   = !issued ? 1 : timed_out ? 1 + TIMEOUT : 2 + d;
        @(posedge clk); #1;
        valid = 1'b1; control = ctrl; addr_in = addr; sd_in = sd;
        stall_cnt = 0; acc = cyc; last_res_cyc = -1;
        @(posedge clk); #1;
        valid = 1'b0; control = 6'b000000; addr_in = $urandom; sd_in = $urandom;
        if (issued) begin
            repeat (d) begin @(posedge clk); #1; end
            mem_ack = 1'b1; mem_rdata = rdata;
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = $urandom;
        end
        got = 0;
        for (int i = 0; i < 4 * TIMEOUT; i++) begin
            @(negedge clk);
            if (!stall_o) begin got = 1; break; end
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL %s stall release: stall still 1, expected 0 within bound", name);
        end
        repeat (2) begin @(posedge clk); #1; end
        check({name, " stall cycles"}, stall_cnt, exp_stall);
        if (has_res) check({name, " result latency"}, last_res_cyc - acc, exp_lat);
    endtask

    initial begin : monitor
        req_t er;
        res_t es;
        forever begin
            @(negedge clk);
            if (rst) begin
                req_seen = 1'b0;
                continue;
            end
            if (stall_o) stall_cnt++;
            if (mem_req_o && !req_seen) begin
                req_seen = 1'b1;
                if (req_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected mem_req: addr 0x%08h, expected no request", mem_addr_o);
                end else begin
                    er = req_q.pop_front();
                    check("mem_we", 32'(mem_we_o), 32'(er.we));
                    check("mem_addr", mem_addr_o, er.addr);
                    check("mem_be", 32'(mem_be_o), 32'(er.be));
                    if (er.we) check("mem_wdata", mem_wdata_o, er.wdata);
                end
            end
            if (!mem_req_o) req_seen = 1'b0;
            if (wb_valid_o || err_o) begin
                last_res_cyc = cyc;
                if (res_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected result: wb_valid %0b err %0b, expected none",
                             wb_valid_o, err_o);
                end else begin
                    es = res_q.pop_front();
                    check("err", 32'(err_o), 32'(es.is_err));
                    check("wb_valid", 32'(wb_valid_o), 32'(!es.is_err));
                    if (!es.is_err) check("wb_data", wb_data_o, es.data);
                end
            end
        end
    end

    initial begin : stimulus
        req_t rq;
        res_t rs;
        bit m, iss, hr;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset stall", 32'(stall_o), 0);
        check("reset wb_data", wb_data_o, 0);
        check("reset wb_valid", 32'(wb_valid_o), 0);
        check("reset err", 32'(err_o), 0);
        check("reset mem_req", 32'(mem_req_o), 0);
        check("reset mem_we", 32'(mem_we_o), 0);
        check("reset mem_addr", mem_addr_o, 0);
        check("reset mem_be", 32'(mem_be_o), 0);
        check("reset mem_wdata", mem_wdata_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        // Stray ack while idle must be ignored.
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        @(posedge clk); #1;
        mem_ack = 1'b0;

        do_op(6'b011010, 32'h104, 32'hDEADBEEF, 0, 32'h0, "sw");
        do_op(6'b011000, 32'h203, 32'h000000A5, 1, 32'h0, "sb");
        do_op(6'b010000, 32'h101, 32'h0, 0, 32'h0000F000, "lb");
        do_op(6'b010100, 32'h101, 32'h0, 0, 32'h0000F000, "lbu");
        do_op(6'b010001, 32'h102, 32'h0, 0, 32'h80010000, "lh");
        do_op(6'b010101, 32'h102, 32'h0, 2, 32'h80010000, "lhu");
        do_op(6'b010010, 32'h103, 32'h0, 1, 32'hCAFEF00D, "lw misaligned");
        do_op(6'b011001, 32'h301, 32'h0000BEEF, 0, 32'h0, "sh misaligned");
        do_op(6'b010010, 32'h400, 32'h0, TIMEOUT + 2, 32'h11111111, "lw timeout");
        do_op(6'b011010, 32'h404, 32'h55AA55AA, TIMEOUT, 32'h0, "sw timeout");
        do_op(6'b010001, 32'h502, 32'h0, TIMEOUT - 1, 32'h7FFF1234, "lh last-cycle ack");
        do_op(6'b000000, 32'h600, 32'h0, 0, 32'h0, "non-mem");

        // Reset while in REQ: request drops and a later ack is ignored.
        model(6'b010010, 32'h700, 32'h0, 32'h0, m, iss, hr, rq, rs);
        req_q.push_back(rq);
        @(posedge clk); #1;
        valid = 1'b1; control = 6'b010010; addr_in = 32'h700;
        @(posedge clk); #1;
        valid = 1'b0; control = 6'b000000;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post-reset mem_req", 32'(mem_req_o), 0);
        check("post-reset stall", 32'(stall_o), 0);
        check("post-reset wb_data", wb_data_o, 0);
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        for (int i = 0; i < 150; i++) begin
            logic [5:0]  c;
            logic [31:0] a, s;
            int k, p, d;
            k = $urandom_range(0, 9);
            if (k < 8) c = ops[k];
            else c = {2'b00, 4'($urandom)};
            a = $urandom;
            s = $urandom;
            if (c == 6'b011000) s = s & 32'hFF;
            if (c == 6'b011001) s = s & 32'hFFFF;
            p = $urandom_range(0, 19);
            if (p < 14) d = $urandom_range(0, 3);
            else if (p < 17) d = TIMEOUT - 1;
            else d = TIMEOUT + $urandom_range(0, 3);
            do_op(c, a, s, d, $urandom, "rand");
        end

        repeat (4) @(posedge clk);
        check("pending requests", req_q.size(), 0);
        check("pending results", res_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
